regfile_read_bypass: RTL and testbench
======================================

Name: regfile_read_bypass

Overview:
- Architectural register file that sits at the far end of the writeback interface, consuming reg_wen / wr_reg / write data each cycle.
- Serves two registered read ports to the decode/execute stage.
- Same-cycle write-to-read bypass.
- Stall-aware refresh of held read outputs, so a stalled consumer never sees a stale operand.

Parameters:
WIDTH, 16, data width of each register and of all data ports
REG_COUNT, 32, number of implemented registers (2..32); index 0 is hardwired zero

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
reg_wen  input  1  write enable from writeback stage
wr_reg  input  5  write register index
wr_data  input  WIDTH  write data (writeback stage result)
rd_en  input  1  read advance; 0 = decode stalled, hold read outputs
rs1_addr  input  5  read port 1 index
rs2_addr  input  5  read port 2 index
rs1_data  output  WIDTH  registered read data, port 1
rs2_data  output  WIDTH  registered read data, port 2

Behaviour:
- Reset (rst_n low, asynchronous, takes effect immediately):
  - All REG_COUNT registers = 0.
  - rs1_data = rs2_data = 0.
  - Internal latched read indices = 0.
  - Operation resumes on the first rising edge after rst_n deasserts.
  - Reset mid-write: the write is lost.
- Write qualification: write_ok = reg_wen && wr_reg != 0 && wr_reg < REG_COUNT.
  - On a rising edge with write_ok, regs[wr_reg] <= wr_data.
  - Otherwise no register changes; writes to x0 or out-of-range indices are silently dropped.
- Read validity: an index is readable iff it is nonzero and < REG_COUNT. Index 0 or out-of-range reads return 0.
- rd_en=1, per port p (independent, identical logic), on the rising edge:
  - latched_p <= rsp_addr.
  - rsp_data <= 0 if rsp_addr is not readable.
  - else rsp_data <= wr_data if write_ok && wr_reg == rsp_addr (bypass, write-first).
  - else rsp_data <= regs[rsp_addr] (pre-edge value).
  - Latency: data for an address presented in cycle N is valid after edge N; one-cycle registered read.
- rd_en=0 (stall), per port p:
  - latched_p and rsp_addr inputs are ignored.
  - rsp_data holds, except when write_ok && wr_reg == latched_p: then rsp_data <= wr_data (refresh), so a held operand tracks writeback of its register.
  - A latched index of 0 or out-of-range never refreshes and stays 0.
- Both ports may address the same register; both receive identical data, including bypass and refresh.
- Read-after-write one cycle apart: the register array already holds the value, so no bypass is needed.
- No combinational path from any input to any output; all outputs come straight from flops.
- No X propagation: every output is defined from reset onward.

Test Plan:
- Reset with rst_n=0 mid-cycle -> rs1_data=rs2_data=0 immediately. After release, read x5 -> 0.
- Write x3=0x1234 (reg_wen=1), next cycle rd_en=1 rs1_addr=3 -> after edge rs1_data=0x1234. Same cycle rs2_addr=0 -> rs2_data=0.
- Bypass: same edge reg_wen=1 wr_reg=7 wr_data=0xBEEF, rd_en=1 rs1_addr=7 rs2_addr=7 -> rs1_data=rs2_data=0xBEEF. x7 later reads 0xBEEF.
- x0 and range checks:
  - Write wr_reg=0 wr_data=0xFFFF, then read x0 -> 0.
  - With REG_COUNT=8, write x9=0x55AA -> read x9 returns 0; x1 is unchanged.
- Stall refresh:
  - Latch rs1_addr=4 (x4=0x0011).
  - rd_en=0 with writes x4=0x2222, then x6=0x3333, while rs1_addr toggles to 6.
  - Required: rs1_data=0x0011, then 0x2222, then still 0x2222.
  - After rd_en=1 with rs1_addr=6 -> rs1_data=0x3333.
- Back-to-back: write x1..x31 with values i*3 on consecutive cycles while reading the previous index each cycle -> every read returns the just-written value with 1-cycle latency. No mismatches.

Source files
------------

// File: rtl/regfile_read_bypass.sv
`default_nettype none
// ============================================================================
// Module   : regfile_read_bypass
// Brief    : Architectural register file with two registered read ports,
//            same-cycle write-to-read bypass and refresh of held operands
//            while decode is stalled. Index 0 is hardwired to zero.
// Revision : 1.0 - initial release
// ============================================================================
module regfile_read_bypass #(
  parameter int WIDTH     = 16,
  parameter int REG_COUNT = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             reg_wen,
  input  logic [4:0]       wr_reg,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  input  logic [4:0]       rs1_addr,
  input  logic [4:0]       rs2_addr,
  output logic [WIDTH-1:0] rs1_data,
  output logic [WIDTH-1:0] rs2_data
);

  // Six bits so that REG_COUNT = 32 is representable in the range compare.
  localparam logic [5:0] C_REG_COUNT = 6'(REG_COUNT);
  localparam int         C_NUM_PORTS = 2;

  logic                 write_ok;
  logic [WIDTH-1:0]     rf_view   [32];
  logic [4:0]           rd_addr   [C_NUM_PORTS];
  logic [WIDTH-1:0]     port_data [C_NUM_PORTS];

  // Writes to x0 or beyond the implemented range are dropped here, which also
  // means a matching write_ok always targets a readable index.
  assign write_ok = reg_wen && (wr_reg != 5'd0) && ({1'b0, wr_reg} < C_REG_COUNT);

  assign rd_addr[0] = rs1_addr;
  assign rd_addr[1] = rs2_addr;

  // Full 32-entry view of the file: unimplemented and zero entries read as 0,
  // so the read muxes can index with the raw 5-bit address.
  generate
    for (genvar i = 0; i < 32; i++) begin : g_reg
      if ((i != 0) && (i < REG_COUNT)) begin : g_impl
        logic [WIDTH-1:0] reg_d;
        logic [WIDTH-1:0] reg_q;

        // Next value of this register: load on a qualified write to it.
        always_comb begin
          reg_d = reg_q;
          if (write_ok && (wr_reg == 5'(i))) begin
            reg_d = wr_data;
          end
        end

        // Register storage, cleared on reset.
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) begin
            reg_q <= '0;
          end else begin
            reg_q <= reg_d;
          end
        end

        assign rf_view[i] = reg_q;
      end else begin : g_zero
        assign rf_view[i] = '0;
      end
    end
  endgenerate

  // Two identical read ports.
  generate
    for (genvar p = 0; p < C_NUM_PORTS; p++) begin : g_port
      logic [4:0]       latched_d;
      logic [4:0]       latched_q;
      logic [WIDTH-1:0] data_d;
      logic [WIDTH-1:0] data_q;
      logic             addr_readable;

      assign addr_readable = (rd_addr[p] != 5'd0) && ({1'b0, rd_addr[p]} < C_REG_COUNT);

      // Advance: latch the index and read with write-first bypass.
      // Stall: hold, but follow writeback of the held register so the
      // stalled consumer never sees a stale operand.
      always_comb begin
        latched_d = latched_q;
        data_d    = data_q;
        if (rd_en) begin
          latched_d = rd_addr[p];
          if (!addr_readable) begin
            data_d = '0;
          end else if (write_ok && (wr_reg == rd_addr[p])) begin
            data_d = wr_data;
          end else begin
            data_d = rf_view[rd_addr[p]];
          end
        end else if (write_ok && (wr_reg == latched_q)) begin
          data_d = wr_data;
        end
      end

      // Read port state: latched index and output data flop.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          latched_q <= '0;
          data_q    <= '0;
        end else begin
          latched_q <= latched_d;
          data_q    <= data_d;
        end
      end

      assign port_data[p] = data_q;
    end
  endgenerate

  assign rs1_data = port_data[0];
  assign rs2_data = port_data[1];

endmodule
`default_nettype wire

// File: tb/tb_regfile_read_bypass.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile_read_bypass
// Brief    : Scoreboard bench for regfile_read_bypass. Two instances are run
//            side by side (REG_COUNT 32 and 8) from the same stimulus; a
//            reference model predicts each cycle's outputs into a queue that a
//            separate monitor drains after every rising edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_regfile_read_bypass;

  localparam int WIDTH = 16;
  localparam int RC_A  = 32;
  localparam int RC_B  = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             reg_wen = 1'b0;
  logic [4:0]       wr_reg = '0;
  logic [WIDTH-1:0] wr_data = '0;
  logic             rd_en = 1'b0;
  logic [4:0]       rs1_addr = '0;
  logic [4:0]       rs2_addr = '0;
  logic [WIDTH-1:0] a_rs1, a_rs2, b_rs1, b_rs2;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  regfile_read_bypass #(.WIDTH(WIDTH), .REG_COUNT(RC_A)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .reg_wen(reg_wen), .wr_reg(wr_reg),
    .wr_data(wr_data), .rd_en(rd_en), .rs1_addr(rs1_addr),
    .rs2_addr(rs2_addr), .rs1_data(a_rs1), .rs2_data(a_rs2)
  );

  regfile_read_bypass #(.WIDTH(WIDTH), .REG_COUNT(RC_B)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .reg_wen(reg_wen), .wr_reg(wr_reg),
    .wr_data(wr_data), .rd_en(rd_en), .rs1_addr(rs1_addr),
    .rs2_addr(rs2_addr), .rs1_data(b_rs1), .rs2_data(b_rs2)
  );

  // Reference model state: [instance][index]
  logic [WIDTH-1:0] m_mem [2][32];
  logic [4:0]       m_lat [2][2];
  logic [WIDTH-1:0] m_out [2][2];
  int               m_rc  [2] = '{RC_A, RC_B};

  // Expected outputs {a_rs1, a_rs2, b_rs1, b_rs2} for the next edge.
  logic [4*WIDTH-1:0] sb_q [$];

  task automatic check(input string name, input logic [WIDTH-1:0] act,
                       input logic [WIDTH-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: actual=%h required=%h", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      for (int r = 0; r < 32; r++) m_mem[k][r] = '0;
      for (int p = 0; p < 2; p++) begin
        m_lat[k][p] = '0;
        m_out[k][p] = '0;
      end
    end
  endtask

  // Drive one cycle of inputs, predict the post-edge outputs, push them.
  task automatic cycle(input logic wen, input logic [4:0] wr,
                       input logic [WIDTH-1:0] wd, input logic ren,
                       input logic [4:0] a1, input logic [4:0] a2);
    logic [4:0] addr [2];
    bit         wok;
    @(negedge clk);
    reg_wen = wen; wr_reg = wr; wr_data = wd;
    rd_en = ren; rs1_addr = a1; rs2_addr = a2;
    addr[0] = a1; addr[1] = a2;
    for (int k = 0; k < 2; k++) begin
      wok = wen && (wr != 0) && (int'(wr) < m_rc[k]);
      for (int p = 0; p < 2; p++) begin
        if (ren) begin
          m_lat[k][p] = addr[p];
          if (addr[p] == 0 || int'(addr[p]) >= m_rc[k]) m_out[k][p] = '0;
          else if (wok && wr == addr[p])               m_out[k][p] = wd;
          else                                         m_out[k][p] = m_mem[k][addr[p]];
        end else if (wok && wr == m_lat[k][p]) begin
          m_out[k][p] = wd;
        end
      end
      if (wok) m_mem[k][wr] = wd;
    end
    sb_q.push_back({m_out[0][0], m_out[0][1], m_out[1][0], m_out[1][1]});
  endtask

  // Asynchronous reset asserted mid-cycle; outputs must clear at once.
  task automatic do_reset();
    @(negedge clk);
    reg_wen = 1'b0; rd_en = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("reset_a_rs1", a_rs1, '0);
    check("reset_a_rs2", a_rs2, '0);
    check("reset_b_rs1", b_rs1, '0);
    check("reset_b_rs2", b_rs2, '0);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    #1 rst_n = 1'b1;
  endtask

  // Monitor: compare DUT outputs just after each edge with the oldest prediction.
  initial begin : monitor
    logic [4*WIDTH-1:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        check("a_rs1", a_rs1, e[4*WIDTH-1:3*WIDTH]);
        check("a_rs2", a_rs2, e[3*WIDTH-1:2*WIDTH]);
        check("b_rs1", b_rs1, e[2*WIDTH-1:WIDTH]);
        check("b_rs2", b_rs2, e[WIDTH-1:0]);
      end
    end
  end

  initial begin : stimulus
    logic [4:0] a1, a2;
    model_reset();
    #3;
    check("por_a_rs1", a_rs1, '0);
    check("por_b_rs2", b_rs2, '0);
    #4 rst_n = 1'b1;

    // Read after reset
    cycle(0, 0, 0, 1, 5, 5);
    // Write then read the next cycle; x0 on port 2
    cycle(1, 3, 16'h1234, 0, 0, 0);
    cycle(0, 0, 0, 1, 3, 0);
    // Same-edge bypass on both ports, then a plain read
    cycle(1, 7, 16'hBEEF, 1, 7, 7);
    cycle(0, 0, 0, 1, 7, 3);
    // x0 write dropped
    cycle(1, 0, 16'hFFFF, 1, 0, 0);
    cycle(0, 0, 0, 1, 0, 7);
    // Out-of-range for the 8-entry instance; x1 unaffected
    cycle(1, 1, 16'h0101, 0, 0, 0);
    cycle(1, 9, 16'h55AA, 0, 0, 0);
    cycle(0, 0, 0, 1, 9, 1);
    // Stall refresh
    cycle(1, 4, 16'h0011, 0, 0, 0);
    cycle(0, 0, 0, 1, 4, 9);
    cycle(1, 4, 16'h2222, 0, 6, 6);
    cycle(1, 6, 16'h3333, 0, 6, 4);
    cycle(0, 0, 0, 1, 6, 6);
    // Back-to-back writes with a read of the previous index
    for (int i = 1; i < 32; i++) begin
      cycle(1, 5'(i), 16'(i * 3), 1, 5'(i - 1), 5'(i));
    end
    cycle(0, 0, 0, 1, 31, 30);

    // Randomized traffic, biased toward stalls and address collisions
    for (int n = 0; n < 400; n++) begin
      a1 = 5'($urandom_range(0, 31));
      a2 = ($urandom_range(0, 3) == 0) ? a1 : 5'($urandom_range(0, 31));
      cycle(1'($urandom_range(0, 1)),
            ($urandom_range(0, 2) == 0) ? a1 : 5'($urandom_range(0, 31)),
            16'($urandom), ($urandom_range(0, 3) != 0), a1, a2);
    end

    // Reset mid-run and resume
    do_reset();
    for (int n = 0; n < 100; n++) begin
      a1 = 5'($urandom_range(0, 31));
      cycle(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), 16'($urandom),
            ($urandom_range(0, 2) != 0), a1, 5'($urandom_range(0, 31)));
    end

    @(negedge clk);
    @(negedge clk);
    n_vec++;
    if (sb_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: actual=%0d pending required=0", sb_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
